// File: rtl/bitrev_rr_sched_if.sv
// Request/response bundle for bitrev_rr_sched: NUM_REQ valid/ready request
// ports feeding one valid/ready output carrying the reversed word and its source index.
interface bitrev_rr_sched_if #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_WIDTH-1:0]           out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/bitrev_rr_sched.sv
// Round-robin shared bit-reversal stage with a single registered output slot.
// Optional BITREV_SCHED_STATS_EN adds out_count (transfer counter) and out_stall.
module bitrev_rr_sched #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   resetn,
    bitrev_rr_sched_if.slave       bus
`ifdef BITREV_SCHED_STATS_EN
    ,
    output logic [15:0]            out_count,
    output logic                   out_stall
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

    logic                  load;
    logic                  found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] rev_data;
    int unsigned           scan_idx;

    always_comb begin
        load      = (state_q == EMPTY) || bus.out_ready;
        found     = 1'b0;
        grant_idx = '0;
        sel_data  = '0;
        scan_idx  = 0;
        // Circular scan starting at the pointer; first valid requester wins.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = (32'(ptr_q) + i) % unsigned'(NUM_REQ);
            if (!found && bus.req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = ID_WIDTH'(scan_idx);
                sel_data  = bus.req_data[scan_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        rev_data = '0;
        for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
            rev_data[DATA_WIDTH-1-k] = sel_data[k];
        end

        bus.req_ready = '0;
        if (load && found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end

        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (found) begin
                state_d = FULL;
                data_d  = rev_data;
                id_d    = grant_idx;
                ptr_d   = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;

`ifdef BITREV_SCHED_STATS_EN
    logic [15:0] count_q, count_d;
    logic        stall_q, stall_d;

    always_comb begin
        count_d = count_q;
        if (bus.out_valid && bus.out_ready) begin
            count_d = count_q + 16'd1;
        end
        stall_d = bus.out_valid && !bus.out_ready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign out_count = count_q;
    assign out_stall = stall_q;
`endif

endmodule
